// File: rtl/vga_timing_pkg.sv
// Shared VGA timing definitions: 640x480@60 default constants, the receiver
// lock-state enum and a saturating counter helper. The same constants drive
// the VGA generator so that transmitter and receiver agree on geometry.
package vga_timing_pkg;

  localparam int VGA_H_TOTAL     = 800;
  localparam int VGA_V_TOTAL     = 525;
  localparam int VGA_H_ACT_START = 144;
  localparam int VGA_H_ACTIVE    = 640;
  localparam int VGA_V_ACT_START = 35;
  localparam int VGA_V_ACTIVE    = 480;

  // Ceiling of the 10-bit line/column counters; reaching it means sync was lost.
  localparam logic [9:0] CNT_MAX = 10'd1023;

  typedef enum logic [1:0] {
    ST_SEARCH = 2'd0,
    ST_TRACK  = 2'd1,
    ST_LOCKED = 2'd2
  } rx_state_e;

  function automatic logic [9:0] cnt_inc(input logic [9:0] c);
    return (c == CNT_MAX) ? c : c + 10'd1;
  endfunction

endpackage

// File: rtl/vga_sync_edge.sv
// Sync input stage: registers one sync pin (stage 1) and flags its leading
// edge, i.e. the first stage-1 cycle at the asserted level.
//   clk_i   pixel clock
//   rst_i   asynchronous active-high reset
//   sync_i  raw sync pin
//   lead_o  leading-edge strobe, aligned with the stage-1 sample
module vga_sync_edge #(
  parameter bit POL = 1'b1
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic sync_i,
  output logic lead_o
);

  logic s1_q, prev_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      s1_q   <= 1'b0;
      prev_q <= 1'b0;
    end else begin
      s1_q   <= sync_i;
      prev_q <= s1_q;
    end
  end

  assign lead_o = (s1_q == POL) && (prev_q != POL);

endmodule

// File: rtl/vga_timing_rx.sv
// VGA timing receiver: measures line/frame geometry from hsync/vsync, locks
// after LOCK_FRAMES consecutive clean frames and then emits active-area pixel
// coordinates with the pixel data, two vga_clk cycles after the pins.
//   vga_clk, sys_rst       clock / async active-high reset
//   hsync, vsync, vga_rgb  VGA source pins (RGB444)
//   rx_x, rx_y, rx_rgb     active pixel position and data (0 outside active)
//   rx_de                  pixel valid
//   frame_start            pulse with the first active pixel of each frame
//   locked                 timing lock status
//   err_cnt                saturating count of lock losses
module vga_timing_rx
  import vga_timing_pkg::*;
#(
  parameter int H_TOTAL     = VGA_H_TOTAL,
  parameter int V_TOTAL     = VGA_V_TOTAL,
  parameter int H_ACT_START = VGA_H_ACT_START,
  parameter int H_ACTIVE    = VGA_H_ACTIVE,
  parameter int V_ACT_START = VGA_V_ACT_START,
  parameter int V_ACTIVE    = VGA_V_ACTIVE,
  parameter bit SYNC_POL    = 1'b1,
  parameter int LOCK_FRAMES = 2
) (
  input  logic        vga_clk,
  input  logic        sys_rst,
  input  logic        hsync,
  input  logic        vsync,
  input  logic [11:0] vga_rgb,
  output logic [9:0]  rx_x,
  output logic [9:0]  rx_y,
  output logic [11:0] rx_rgb,
  output logic        rx_de,
  output logic        frame_start,
  output logic        locked,
  output logic [7:0]  err_cnt
);

  localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);
  localparam logic [9:0] HS     = 10'(H_ACT_START);
  localparam logic [9:0] HE     = 10'(H_ACT_START + H_ACTIVE);
  localparam logic [9:0] VS     = 10'(V_ACT_START);
  localparam logic [9:0] VE     = 10'(V_ACT_START + V_ACTIVE);
  localparam logic [7:0] LOCK_N = 8'(LOCK_FRAMES);

  // Stage 1
  logic        hs_lead, vs_lead;
  logic [11:0] rgb_s1_q;

  vga_sync_edge #(.POL(SYNC_POL)) u_hs (
    .clk_i(vga_clk), .rst_i(sys_rst), .sync_i(hsync), .lead_o(hs_lead)
  );
  vga_sync_edge #(.POL(SYNC_POL)) u_vs (
    .clk_i(vga_clk), .rst_i(sys_rst), .sync_i(vsync), .lead_o(vs_lead)
  );

  // Counters
  logic [9:0] h_cnt_q, h_cnt_d, v_cnt_q, v_cnt_d;
  logic       bad_line, bad_frame, bad;

  always_comb begin
    h_cnt_d = hs_lead ? 10'd0 : cnt_inc(h_cnt_q);
    if (vs_lead)      v_cnt_d = 10'd0;
    else if (hs_lead) v_cnt_d = cnt_inc(v_cnt_q);
    else              v_cnt_d = v_cnt_q;
  end

  // h_cnt parked at the ceiling means no hsync for a whole counter span.
  assign bad_line  = (hs_lead && (h_cnt_q != H_LAST)) || (h_cnt_q == CNT_MAX);
  assign bad_frame = vs_lead && (v_cnt_q != V_LAST);
  assign bad       = bad_line || bad_frame;

  // Lock FSM
  rx_state_e  state_q, state_d;
  logic [7:0] gf_q, gf_d;
  logic [7:0] err_q, err_d;

  always_comb begin
    state_d = state_q;
    gf_d    = gf_q;
    err_d   = err_q;
    case (state_q)
      ST_SEARCH: begin
        if (vs_lead) begin
          state_d = ST_TRACK;
          gf_d    = 8'd0;
        end
      end
      ST_TRACK: begin
        if (bad) begin
          state_d = ST_SEARCH;
        end else if (vs_lead) begin
          gf_d = gf_q + 8'd1;
          if (gf_q + 8'd1 >= LOCK_N) state_d = ST_LOCKED;
        end
      end
      ST_LOCKED: begin
        // Bad wins even when a good vsync edge lands in the same cycle.
        if (bad) begin
          state_d = ST_SEARCH;
          if (err_q != 8'hFF) err_d = err_q + 8'd1;
        end
      end
      default: state_d = ST_SEARCH;
    endcase
  end

  // Output stage: driven from the next-state counters so the outputs sit one
  // register after stage 1.
  logic        locked_q, locked_d;
  logic        de_q, de_d, fs_q, fs_d;
  logic [9:0]  x_q, x_d, y_q, y_d;
  logic [11:0] rgb_q, rgb_d;

  always_comb begin
    locked_d = (state_q == ST_LOCKED);
    de_d     = locked_q && (h_cnt_d >= HS) && (h_cnt_d < HE)
                        && (v_cnt_d >= VS) && (v_cnt_d < VE);
    x_d      = de_d ? h_cnt_d - HS : 10'd0;
    y_d      = de_d ? v_cnt_d - VS : 10'd0;
    rgb_d    = de_d ? rgb_s1_q : 12'd0;
    fs_d     = de_d && (h_cnt_d == HS) && (v_cnt_d == VS);
  end

  always_ff @(posedge vga_clk or posedge sys_rst) begin
    if (sys_rst) begin
      rgb_s1_q <= 12'd0;
      h_cnt_q  <= 10'd0;
      v_cnt_q  <= 10'd0;
      state_q  <= ST_SEARCH;
      gf_q     <= 8'd0;
      err_q    <= 8'd0;
      locked_q <= 1'b0;
      de_q     <= 1'b0;
      fs_q     <= 1'b0;
      x_q      <= 10'd0;
      y_q      <= 10'd0;
      rgb_q    <= 12'd0;
    end else begin
      rgb_s1_q <= vga_rgb;
      h_cnt_q  <= h_cnt_d;
      v_cnt_q  <= v_cnt_d;
      state_q  <= state_d;
      gf_q     <= gf_d;
      err_q    <= err_d;
      locked_q <= locked_d;
      de_q     <= de_d;
      fs_q     <= fs_d;
      x_q      <= x_d;
      y_q      <= y_d;
      rgb_q    <= rgb_d;
    end
  end

  assign rx_x        = x_q;
  assign rx_y        = y_q;
  assign rx_rgb      = rgb_q;
  assign rx_de       = de_q;
  assign frame_start = fs_q;
  assign locked      = locked_q;
  assign err_cnt     = err_q;

endmodule
